mux8_rr_arbiter: RTL
====================

// Module: mux8_rr_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for the shared 8:1 single-bit mux.
//  Eight requesters contend for the mux. The block drives the 3-bit mux select
//  and returns a registered copy of the selected bit, tagged with a valid strobe.
//  Grant length is capped, so no requester can monopolise the mux.
//  It sits between the requesting logic and the mux datapath on the FPGA board design.
// PARAMETERS
//  HOLD_CYCLES  4  max consecutive grant cycles per requester (legal range 1..255; 0 is illegal)
//  CNT_W        8  width of the hold counter (must hold HOLD_CYCLES-1)
// PORTS
//  clk      in   1  single clock, rising edge
//  rst      in   1  synchronous, active-high reset
//  req      in   8  request vector; req[i] is held high while requester i wants the mux
//  data_in  in   8  mux data inputs; bit i is input i (A=bit0 .. H=bit7)
//  grant    out  8  one-hot grant, all-zero when idle
//  select   out  3  mux select, equal to the index of the granted bit; 0 when idle
//  busy     out  1  high while in state GRANT
//  valid    out  1  muxout is meaningful this cycle
//  muxout   out  1  registered data_in[select]
// BEHAVIOUR
//  Reset (sampled on clk):
//   - grant=0, select=0, busy=0, valid=0, muxout=0.
//   - ptr=0, cnt=0, state=IDLE.
//   - Reset overrides every other event, including a grant in progress: grant drops at that edge.
//  State IDLE:
//   - If req!=0, pick the first i with req[i]=1, searching ptr, ptr+1, .. wrapping 7->0.
//   - At that edge: grant=1<<i, select=i, cnt=HOLD_CYCLES-1, state=GRANT.
//   - If req==0, stay in IDLE with grant=0.
//  State GRANT (all tests use the values registered at the previous edge):
//   - If req[select]=0: release. Next edge gives grant=0, select=0, state=IDLE, ptr=select+1 mod 8.
//   - Else if cnt==0: forced rotate, with the same updates as release.
//   - Else cnt=cnt-1 and the grant is kept.
//  Fixed bubble: exactly one IDLE cycle (grant=0) follows every grant.
//   - The bubble applies even if other requests are pending.
//   - The next arbitration happens at the edge ending that IDLE cycle.
//   - Net effect: a requester held high gets HOLD_CYCLES grant cycles then 1 idle cycle.
//  Arbitration point: req changes seen during GRANT never preempt the current grant.
//  Pointer wrap: after a grant to index 7, ptr=0.
//  busy = (state==GRANT). It is combinational from the state register, so it aligns with grant.
//  Data path, both outputs registered with 1-cycle latency behind grant:
//   - valid  <= (state==GRANT)
//   - muxout <= (state==GRANT) ? data_in[select] : 0
//   - So valid/muxout are delayed by one cycle relative to grant. The final valid cycle
//     coincides with the first bubble cycle.
//  Ignored inputs: data_in bits other than data_in[select] have no effect; req bits of
//   non-granted requesters only matter at arbitration.
//  Simultaneous case: a release and a new request from another requester in the same cycle
//   still incur the single bubble, with no back-to-back grants.
// TESTING
//  1. rst=1 for 2 cycles with req=8'hFF -> grant=0, select=0, valid=0, muxout=0 throughout.
//     After release, first grant=8'h01.
//  2. HOLD_CYCLES=4, req=8'h04 held -> grant=8'h04 and select=2 for 4 cycles, then 1 cycle
//     grant=0, then regrant 8'h04. valid follows one cycle later.
//  3. req=8'hFF held -> grant sequence 01,02,04,..,80,01; each lasts 4 cycles plus 1 bubble.
//     Checks the 7->0 wrap.
//  4. req=8'h68 from IDLE with ptr=0 -> grant 8'h08. Drop req[3] after 2 grant cycles ->
//     grant=0 next edge, ptr=4. Next grant 8'h20, then 8'h40.
//  5. Grant on index 1, toggle data_in[1] 0,1,1,0 and randomise the other bits ->
//     muxout=0,1,1,0 lagging one cycle with valid=1; other bits have no effect.
//  6. Assert rst in the 2nd cycle of grant 8'h10 -> grant=0, busy=0 at that edge,
//     valid=0 next cycle. After rst drops with req=8'h10, grant 8'h10 again from ptr=0.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for a shared 8:1 single-bit mux. It caps grant length and inserts
// one idle cycle after every grant. Returns a registered copy of the selected bit.
module mux8_rr_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] data_in,
    output logic [7:0] grant,
    output logic [2:0] select,
    output logic       busy,
    output logic       valid,
    output logic       muxout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             muxout_q, muxout_d;

    logic [2:0]       pick_idx;
    logic             pick_found;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 3'd0;
            sel_q    <= 3'd0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            muxout_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            muxout_q <= muxout_d;
        end
    end

    // Rotating priority search: first requester at or after ptr, wrapping 7 -> 0.
    always_comb begin
        pick_idx   = 3'd0;
        pick_found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!pick_found && req[ptr_q + 3'(k)]) begin
                pick_idx   = ptr_q + 3'(k);
                pick_found = 1'b1;
            end
        end
    end

    // NOTE: every signal gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            GRANT: begin
                if (!req[sel_q] || cnt_q == '0) begin
                    state_d = IDLE;
                    sel_d   = 3'd0;
                    ptr_d   = sel_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The data path lags the grant by one cycle.
    always_comb begin
        valid_d  = (state_q == GRANT);
        muxout_d = (state_q == GRANT) && data_in[sel_q];
    end

    always_comb begin
        busy   = (state_q == GRANT);
        grant  = (state_q == GRANT) ? (8'b1 << sel_q) : 8'h00;
        select = (state_q == GRANT) ? sel_q : 3'd0;
        valid  = valid_q;
        muxout = muxout_q;
    end

endmodule
